freelist_ctrl: RTL and testbench

FREELIST_CTRL -- requirements
Module: freelist_ctrl

---
 rtl/rename_pkg.sv | 11 +
 rtl/lane_prefix_cnt.sv | 19 +
 rtl/freelist_ctrl.sv | 136 +++++++++++++
 tb/tb_freelist_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage constants and the physical register handle type.
// Used by freelist_ctrl, rename and rat_update.
package rename_pkg;
  localparam int DEF_NUM_PHY    = 380;
  localparam int DEF_NUM_ARCH   = 31;
  localparam int DEF_NUM_DECODE = 4;
  localparam int DEF_NUM_COMMIT = 4;
  localparam int PHY_WIDTH      = $clog2(DEF_NUM_PHY);

  typedef logic [PHY_WIDTH-1:0] phyreg_t;
endpackage

// File: rtl/lane_prefix_cnt.sv
// Exclusive prefix popcount per lane (lane 0 = bit 0) plus the total set count.
module lane_prefix_cnt #(
  parameter  int LANES = 4,
  localparam int CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]         mask,
  output logic [LANES-1:0][CW-1:0] prefix,
  output logic [CW-1:0]            total
);
  always_comb begin : scan
    logic [CW-1:0] acc;
    acc = '0;
    for (int k = 0; k < LANES; k++) begin
      prefix[k] = acc;
      acc       = acc + CW'(mask[k]);
    end
    total = acc;
  end
endmodule

// File: rtl/freelist_ctrl.sv
// Physical register free list: multi-lane allocate at head, compacted free at tail.
// Define FREELIST_CKPT_EN to add branch checkpoint save/restore of the head pointer.
module freelist_ctrl import rename_pkg::*; #(
  parameter  int NUM_DECODE = DEF_NUM_DECODE,
  parameter  int NUM_COMMIT = DEF_NUM_COMMIT,
  parameter  int NUM_PHY    = DEF_NUM_PHY,
  parameter  int NUM_ARCH   = DEF_NUM_ARCH,
  localparam int PW         = $clog2(NUM_PHY),
  localparam int DEPTH      = NUM_PHY - NUM_ARCH,
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef FREELIST_CKPT_EN
  input  logic                     ckpt_save,
  input  logic                     ckpt_restore,
`endif
  input  logic [NUM_DECODE-1:0]    alloc_req,
  output logic                     alloc_ready,
  output logic [PW*NUM_DECODE-1:0] alloc_phyreg_flatten,
  input  logic [NUM_COMMIT-1:0]    free_valid,
  input  logic [PW*NUM_COMMIT-1:0] free_phyreg_flatten,
  output logic [CNT_WIDTH-1:0]     free_count,
  output logic                     overflow_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int AW    = $clog2(NUM_DECODE + 1);
  localparam int FW    = $clog2(NUM_COMMIT + 1);
  localparam logic [PTR_W:0]     DEPTH_P = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_WIDTH:0] DEPTH_C = (CNT_WIDTH + 1)'(DEPTH);

  // Offsets never exceed DEPTH-1, so one conditional subtract wraps correctly.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                               input logic [PTR_W-1:0] off);
    logic [PTR_W:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[PTR_W-1:0];
  endfunction

  logic [PW-1:0]        entry_reg [DEPTH];
  logic [PTR_W-1:0]     head_reg, head_next, tail_reg, tail_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;
  logic                 overflow_reg, overflow_next;

  logic [NUM_DECODE-1:0]          req_lane;
  logic [NUM_COMMIT-1:0]          fv_lane;
  logic [NUM_COMMIT-1:0][PW-1:0]  fphy_lane;
  logic [NUM_DECODE-1:0][AW-1:0]  a_prefix;
  logic [NUM_COMMIT-1:0][FW-1:0]  f_prefix;
  logic [AW-1:0]                  a_total, n_alloc;
  logic [FW-1:0]                  f_total;
  logic [CNT_WIDTH:0]             base_cnt, sum_cnt;
  logic                           enough, fire, free_ok;

  // Lane 0 sits in the MSBs of every lane-packed port.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DECODE; gi++) begin : g_alloc_lane
      assign req_lane[gi] = alloc_req[NUM_DECODE-1-gi];
      assign alloc_phyreg_flatten[(NUM_DECODE-1-gi)*PW +: PW] =
        req_lane[gi] ? entry_reg[ptr_add(head_reg, PTR_W'(a_prefix[gi]))] : '0;
    end
    for (gi = 0; gi < NUM_COMMIT; gi++) begin : g_free_lane
      assign fv_lane[gi]   = free_valid[NUM_COMMIT-1-gi];
      assign fphy_lane[gi] = free_phyreg_flatten[(NUM_COMMIT-1-gi)*PW +: PW];
    end
  endgenerate

  lane_prefix_cnt #(.LANES(NUM_DECODE)) u_alloc_cnt (
    .mask(req_lane), .prefix(a_prefix), .total(a_total)
  );
  lane_prefix_cnt #(.LANES(NUM_COMMIT)) u_free_cnt (
    .mask(fv_lane), .prefix(f_prefix), .total(f_total)
  );

  assign enough = (count_reg >= CNT_WIDTH'(a_total));
`ifdef FREELIST_CKPT_EN
  logic [PTR_W-1:0] ckpt_head_reg, ckpt_head_next, restore_dist;
  assign restore_dist = (head_reg >= ckpt_head_reg) ? head_reg - ckpt_head_reg
                      : PTR_W'(DEPTH_P - {1'b0, ckpt_head_reg} + {1'b0, head_reg});
  assign alloc_ready  = enough & ~ckpt_restore;
`else
  assign alloc_ready  = enough;
`endif
  assign fire         = alloc_ready & (|alloc_req);
  assign free_count   = count_reg;
  assign overflow_err = overflow_reg;

  always_comb begin
    n_alloc   = fire ? a_total : '0;
    head_next = ptr_add(head_reg, PTR_W'(n_alloc));
    base_cnt  = {1'b0, count_reg} - (CNT_WIDTH + 1)'(n_alloc);
`ifdef FREELIST_CKPT_EN
    ckpt_head_next = ckpt_head_reg;
    if (ckpt_restore) begin
      head_next = ckpt_head_reg;
      base_cnt  = {1'b0, count_reg} + (CNT_WIDTH + 1)'(restore_dist);
    end else if (ckpt_save) begin
      ckpt_head_next = head_next;
    end
`endif
    // A free group that would overfill the list is dropped as a whole.
    sum_cnt       = base_cnt + (CNT_WIDTH + 1)'(f_total);
    free_ok       = (sum_cnt <= DEPTH_C);
    count_next    = free_ok ? sum_cnt[CNT_WIDTH-1:0] : base_cnt[CNT_WIDTH-1:0];
    tail_next     = free_ok ? ptr_add(tail_reg, PTR_W'(f_total)) : tail_reg;
    overflow_next = overflow_reg | ~free_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= PW'(NUM_ARCH + i);
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= CNT_WIDTH'(DEPTH);
      overflow_reg <= 1'b0;
`ifdef FREELIST_CKPT_EN
      ckpt_head_reg <= '0;
`endif
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
`ifdef FREELIST_CKPT_EN
      ckpt_head_reg <= ckpt_head_next;
`endif
      if (free_ok) begin
        for (int k = 0; k < NUM_COMMIT; k++) begin
          if (fv_lane[k]) entry_reg[ptr_add(tail_reg, PTR_W'(f_prefix[k]))] <= fphy_lane[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_freelist_ctrl.sv
// Randomised + directed bench for freelist_ctrl; reference model is a FIFO queue of free regs.
// Checkpoint scenarios are compiled only when FREELIST_CKPT_EN is defined.
module tb_freelist_ctrl;
  import rename_pkg::*;
  localparam int ND = 4, NC = 4, NP = 380, NA = 31;
  localparam int DEPTH = NP - NA, PW = $clog2(NP), CW = $clog2(DEPTH + 1);

  logic clk = 1'b0, rst = 1'b0;
  logic [ND-1:0]    alloc_req = '0;
  logic             alloc_ready;
  logic [PW*ND-1:0] alloc_phyreg_flatten;
  logic [NC-1:0]    free_valid = '0;
  logic [PW*NC-1:0] free_phyreg_flatten = '0;
  logic [CW-1:0]    free_count;
  logic             overflow_err;
  logic             ckpt_save = 1'b0, ckpt_restore = 1'b0;

  always #5 clk = ~clk;

  freelist_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef FREELIST_CKPT_EN
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
`endif
    .alloc_req(alloc_req), .alloc_ready(alloc_ready),
    .alloc_phyreg_flatten(alloc_phyreg_flatten),
    .free_valid(free_valid), .free_phyreg_flatten(free_phyreg_flatten),
    .free_count(free_count), .overflow_err(overflow_err)
  );

  typedef struct {
    logic             ready;
    logic             chk_grant;
    logic [PW*ND-1:0] grant;
    int               count;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   fl[$];          // free registers in allocation order
  int   inflight[$];    // allocated, not yet freed
  int   since_ckpt[$];  // allocated since the checkpoint was taken
  bit   ovf_m;
  int   checks = 0, errors = 0, txn = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s (txn %0d): got %0h, expected %0h", name, txn, act, expv);
    end
  endtask

  // Monitor: every presented cycle is compared against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      txn++;
      $display("txn %0d req=%b fv=%b ready=%b grant=%h cnt=%0d ovf=%b", txn, alloc_req,
               free_valid, alloc_ready, alloc_phyreg_flatten, free_count, overflow_err);
      chk("alloc_ready", longint'(alloc_ready), longint'(e.ready));
      chk("free_count", longint'(free_count), longint'(e.count));
      chk("overflow_err", longint'(overflow_err), longint'(e.ovf));
      if (e.chk_grant) chk("alloc_phyreg", longint'(alloc_phyreg_flatten), longint'(e.grant));
    end
  end

  task automatic model_reset();
    fl.delete(); inflight.delete(); since_ckpt.delete();
    for (int i = 0; i < DEPTH; i++) fl.push_back(NA + i);
    ovf_m = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    alloc_req = ND'($urandom); free_valid = NC'($urandom);
    free_phyreg_flatten = (PW*NC)'({$urandom(), $urandom()});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  // Drive one cycle, queue the expected response, advance the model, wait one edge.
  task automatic step(input logic [ND-1:0] req, input logic [NC-1:0] fv,
                      input logic [PW*NC-1:0] ff, input bit save, input bit restore);
    exp_t e;
    int na, nf, rank, base, v;
    bit rdy, fire;
    alloc_req = req; free_valid = fv; free_phyreg_flatten = ff;
    ckpt_save = save; ckpt_restore = restore;
    na = 0; nf = 0;
    for (int k = 0; k < ND; k++) na += int'(req[k]);
    for (int k = 0; k < NC; k++) nf += int'(fv[k]);
    rdy  = (fl.size() >= na) && !restore;
    fire = rdy && (na > 0);
    e.ready = rdy; e.chk_grant = rdy; e.count = fl.size(); e.ovf = ovf_m; e.grant = '0;
    rank = 0;
    for (int k = 0; k < ND; k++) begin
      if (req[ND-1-k]) begin
        if (rdy) e.grant[(ND-1-k)*PW +: PW] = PW'(fl[rank]);
        rank++;
      end
    end
    exp_q.push_back(e);
    base = fl.size() - (fire ? na : 0) + (restore ? since_ckpt.size() : 0);
    if (fire) begin
      for (int i = 0; i < na; i++) begin
        v = fl.pop_front();
        inflight.push_back(v);
        since_ckpt.push_back(v);
      end
    end
    if (restore) begin
      for (int i = since_ckpt.size() - 1; i >= 0; i--) begin
        fl.push_front(since_ckpt[i]);
        for (int j = 0; j < inflight.size(); j++)
          if (inflight[j] == since_ckpt[i]) begin inflight.delete(j); break; end
      end
      since_ckpt.delete();
    end
    if (base + nf > DEPTH) ovf_m = 1'b1;
    else for (int k = 0; k < NC; k++) if (fv[NC-1-k]) fl.push_back(int'(ff[(NC-1-k)*PW +: PW]));
    if (save && !restore) since_ckpt.delete();
    @(posedge clk); #1;
  endtask

  task automatic rand_step(input bit do_alloc);
    logic [ND-1:0] req;
    logic [NC-1:0] fv;
    logic [PW*NC-1:0] ff;
    int idx;
    req = do_alloc ? ND'($urandom) : '0;
    ff  = (PW*NC)'({$urandom(), $urandom()});
    fv  = '0;
    for (int k = 0; k < NC; k++) begin
      if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, inflight.size() - 1);
        ff[(NC-1-k)*PW +: PW] = PW'(inflight[idx]);
        inflight.delete(idx);
        fv[NC-1-k] = 1'b1;
      end
    end
    step(req, fv, ff, 1'b0, 1'b0);
  endtask

  initial begin
    // Four-lane grant straight out of reset
    do_reset();
    chk("rst_count", longint'(free_count), 349);
    chk("rst_ovf", longint'(overflow_err), 0);
    alloc_req = 4'b1111; #1;
    chk("r033_grant", longint'(alloc_phyreg_flatten), longint'({9'd31, 9'd32, 9'd33, 9'd34}));
    step(4'b1111, '0, '0, 1'b0, 1'b0);
    chk("r033_count", longint'(free_count), 345);

    // Sparse request: unrequested lanes read zero
    do_reset();
    alloc_req = 4'b1010; #1;
    chk("r034_grant", longint'(alloc_phyreg_flatten), longint'({9'd31, 9'd0, 9'd32, 9'd0}));
    step(4'b1010, '0, '0, 1'b0, 1'b0);
    chk("r034_count", longint'(free_count), 347);

    // Near-empty: refused request, same-cycle free only usable next cycle
    do_reset();
    for (int i = 0; i < 86; i++) step(4'b1111, '0, '0, 1'b0, 1'b0);
    step(4'b0111, '0, '0, 1'b0, 1'b0);
    chk("r035_drained", longint'(free_count), 2);
    void'(inflight.pop_front());
    step(4'b0111, 4'b0001, (PW*NC)'(31), 1'b0, 1'b0);
    chk("r035_count", longint'(free_count), 3);
    alloc_req = 4'b0111; free_valid = '0; #1;
    chk("r035_ready", longint'(alloc_ready), 1);
    chk("r035_grant", longint'(alloc_phyreg_flatten), longint'({9'd0, 9'd378, 9'd379, 9'd31}));
    step(4'b0111, '0, '0, 1'b0, 1'b0);

    // Long random run: pointers wrap many times
    for (int i = 0; i < 700; i++) rand_step(1'b1);
    chk("r036_no_ovf", longint'(overflow_err), 0);

    // Return everything, then overfill by one
    for (int i = 0; i < 2000 && inflight.size() > 0; i++) rand_step(1'b0);
    chk("r037_full", longint'(free_count), 349);
    step('0, 4'b1000, {9'd5, 27'd0}, 1'b0, 1'b0);
    chk("r037_ovf", longint'(overflow_err), 1);
    chk("r037_count", longint'(free_count), 349);
    step(4'b1111, '0, '0, 1'b0, 1'b0);
    step('0, '0, '0, 1'b0, 1'b0);
    chk("r037_sticky", longint'(overflow_err), 1);
    do_reset();
    chk("r037_rst_ovf", longint'(overflow_err), 0);
    step('0, '0, '0, 1'b0, 1'b0);

`ifdef FREELIST_CKPT_EN
    // Checkpoint at head=4, allocate 8, restore
    do_reset();
    step(4'b1111, '0, '0, 1'b0, 1'b0);
    step('0, '0, '0, 1'b1, 1'b0);
    step(4'b1111, '0, '0, 1'b0, 1'b0);
    step(4'b1111, '0, '0, 1'b0, 1'b0);
    step(4'b1111, '0, '0, 1'b0, 1'b1);
    chk("r038_count", longint'(free_count), 345);
    alloc_req = 4'b1000; #1;
    chk("r038_grant", longint'(alloc_phyreg_flatten), longint'({9'd35, 27'd0}));
    step(4'b1000, '0, '0, 1'b0, 1'b0);
    // Save together with a fire latches the post-fire head; restore beats save
    step(4'b1100, '0, '0, 1'b1, 1'b0);
    step(4'b1111, 4'b0100, {9'd0, 9'd31, 18'd0}, 1'b0, 1'b0);
    step(4'b1111, '0, '0, 1'b1, 1'b1);
    step('0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) rand_step(1'b1);
`endif

    @(negedge clk); #1;
    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
